byte_fifo: RTL and testbench

//   Synchronous first-word-fall-through byte FIFO, 16 entries deep by default.

---
 rtl/byte_fifo_pkg.sv | 12 +
 rtl/byte_fifo_if.sv | 31 +++
 rtl/byte_fifo_ram.sv | 28 ++
 rtl/byte_fifo.sv | 71 +++++++
 tb/tb_byte_fifo.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/byte_fifo_pkg.sv
// Shared defaults and width helpers for the byte FIFO.
package byte_fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    // Pointer width for a power-of-two depth; count needs one extra bit to hold DEPTH.
    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/byte_fifo_if.sv
// Producer/consumer bus of the byte FIFO; the FIFO owns the slave side.
interface byte_fifo_if
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    // write/read are one-clock strobes with no backpressure: a write while full
    // (and no read) is dropped, and a read while empty is ignored. dataOut holds
    // the oldest entry whenever dataPresent=1. count is a debug view of the fill level.
    logic             write;
    logic             read;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic             dataPresent;
    logic             halfFull;
    logic             full;
    logic [clog2(DEPTH):0] count;

    modport master (
        output write, read, dataIn,
        input  dataOut, dataPresent, halfFull, full, count
    );

    modport slave (
        input  write, read, dataIn,
        output dataOut, dataPresent, halfFull, full, count
    );

endinterface

// File: rtl/byte_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read (LUTRAM friendly).
module byte_fifo_ram
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO: pointers, fill count, accept logic and flags.
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    byte_fifo_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_acc;
    logic          rd_acc;

    // A write into a full FIFO is still taken when the same-cycle read frees a slot.
    always_comb begin
        rd_acc   = bus.read && (count_q != '0);
        wr_acc   = bus.write && ((count_q < CW'(DEPTH)) || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    byte_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.dataIn),
        .raddr (rd_ptr_q),
        .rdata (bus.dataOut)
    );

    assign bus.dataPresent = (count_q != '0);
    assign bus.halfFull    = (count_q >= CW'(DEPTH / 2));
    assign bus.full        = (count_q == CW'(DEPTH));
    assign bus.count       = count_q;

endmodule

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo with an expected-byte queue checked by a read monitor.
module tb_byte_fifo;
  import byte_fifo_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int D = DEPTH_DEF;

  logic clk;
  logic rst;

  byte_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  byte_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_flags(input string name, input logic dp, input logic hf,
                           input logic fu, input int cnt);
    chk({name, "_dataPresent"}, 32'(bus.dataPresent), 32'(dp));
    chk({name, "_halfFull"},    32'(bus.halfFull),    32'(hf));
    chk({name, "_full"},        32'(bus.full),        32'(fu));
    chk({name, "_count"},       32'(bus.count),       32'(cnt));
  endtask

  // driver: one clock of strobes; the expected byte is queued at the edge it is accepted
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
    int  sz;
    logic acc;
    bus.write  = w;
    bus.read   = r;
    bus.dataIn = d;
    sz  = exp_q.size();
    acc = w && ((sz < D) || (r && sz > 0));
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  // scoreboard monitor: every read strobe is checked against the queue head
  always @(negedge clk) begin
    if (!rst && bus.read) begin
      if (exp_q.size() > 0) begin
        chk("pop_present", 32'(bus.dataPresent), 32'd1);
        chk("pop_data", 32'(bus.dataOut), 32'(exp_q.pop_front()));
      end else begin
        chk("empty_read_present", 32'(bus.dataPresent), 32'd0);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.write  = 1'b0;
    bus.read   = 1'b0;
    bus.dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_flags("in_reset", 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // 1: idle after reset
    chk_flags("idle", 1'b0, 1'b0, 1'b0, 0);

    // 2: single byte fall-through
    cycle(1'b1, 1'b0, 8'hA5);
    chk_flags("one", 1'b1, 1'b0, 1'b0, 1);
    chk("one_dout", 32'(bus.dataOut), 32'h0000_00A5);
    cycle(1'b0, 1'b1, 8'h00);
    chk_flags("one_pop", 1'b0, 1'b0, 1'b0, 0);

    // 3: fill to full, drop overflow, drain in order (pointers start mid-array here)
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 6)  chk_flags("fill7",  1'b1, 1'b0, 1'b0, 7);
      if (i == 7)  chk_flags("fill8",  1'b1, 1'b1, 1'b0, 8);
      if (i == 14) chk_flags("fill15", 1'b1, 1'b1, 1'b0, 15);
      if (i == 15) chk_flags("fill16", 1'b1, 1'b1, 1'b1, 16);
    end
    cycle(1'b1, 1'b0, 8'hFF);
    chk_flags("overflow", 1'b1, 1'b1, 1'b1, 16);
    chk("overflow_head", 32'(bus.dataOut), 32'h0000_0000);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_flags("drained", 1'b0, 1'b0, 1'b0, 0);

    // 4: read on empty is ignored
    cycle(1'b0, 1'b1, 8'h00);
    chk_flags("underflow", 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 8'h3C);
    chk_flags("after_underflow", 1'b1, 1'b0, 1'b0, 1);
    chk("after_underflow_dout", 32'(bus.dataOut), 32'h0000_003C);
    cycle(1'b0, 1'b1, 8'h00);

    // 5: simultaneous read+write at full and at empty
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    chk_flags("full_again", 1'b1, 1'b1, 1'b1, 16);
    cycle(1'b1, 1'b1, 8'h77);
    chk_flags("full_rw", 1'b1, 1'b1, 1'b1, 16);
    chk("full_rw_head", 32'(bus.dataOut), 32'h0000_0081);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_flags("full_rw_drained", 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 8'h11);
    chk_flags("empty_rw", 1'b1, 1'b0, 1'b0, 1);
    chk("empty_rw_dout", 32'(bus.dataOut), 32'h0000_0011);
    cycle(1'b0, 1'b1, 8'h00);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
    chk_flags("pre_rst", 1'b1, 1'b0, 1'b0, 5);
    #2;
    rst = 1'b1;
    #1;
    chk_flags("async_rst", 1'b0, 1'b0, 1'b0, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 1'b0, 8'h42);
    chk_flags("post_rst", 1'b1, 1'b0, 1'b0, 1);
    chk("post_rst_dout", 32'(bus.dataOut), 32'h0000_0042);
    cycle(1'b0, 1'b1, 8'h00);
    chk_flags("post_rst_pop", 1'b0, 1'b0, 1'b0, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
